// File: rtl/rk_arith_pkg.sv
// Shared definitions for the Runge-Kutta arithmetic blocks.
package rk_arith_pkg;

   // Default operand width across the arithmetic datapath
   localparam int RK_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Quotient reported when the divisor is zero
   localparam logic [RK_W-1:0] DIV_BY_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
module div_step #(
   parameter int N = 16
) (
   input  logic [N:0]   acc,
   input  logic         q_msb,
   input  logic [N-1:0] b,
   output logic [N:0]   acc_nx,
   output logic         q_bit
);

   logic [N:0] shifted;
   logic [N:0] diff;

   // Shift in the next dividend bit, trial-subtract, restore on borrow.
   // The compare uses the full shifted value; the subtract is done modulo
   // 2^(N+1), which is exact because a kept difference is always below B.
   always_comb begin
      shifted = {acc[N-1:0], q_msb};
      diff    = shifted - {1'b0, b};
      q_bit   = ({acc, q_msb} >= {2'b00, b});
      acc_nx  = q_bit ? diff : shifted;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock, valid/ready on both sides.
import rk_arith_pkg::*;

module seq_divider #(
   parameter int N = RK_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quot,
   output logic [N-1:0] rem,
   output logic         div_by_zero
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
   // Package constant is all-ones at RK_W; replicate so any N stays all-ones
   localparam logic [N-1:0] DBZ_QUOT = {N{DIV_BY_ZERO_QUOT[0]}};

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [N:0]       acc;
   logic [N-1:0]     q;
   logic [N-1:0]     b_r;
   logic [N:0]       acc_nx;
   logic             q_bit;

   div_step #(.N(N)) u_step (
      .acc    (acc),
      .q_msb  (q[N-1]),
      .b      (b_r),
      .acc_nx (acc_nx),
      .q_bit  (q_bit)
   );

   assign in_ready = (state == IDLE);

   // FSM plus datapath: accept operands, iterate N steps, hold result until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         q           <= '0;
         b_r         <= '0;
         out_valid   <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  b_r <= B;
                  q   <= A;
                  acc <= '0;
                  cnt <= '0;
                  if (B == '0) begin
                     // Nothing to iterate: publish the result right away
                     state       <= DONE;
                     out_valid   <= 1'b1;
                     quot        <= DBZ_QUOT;
                     rem         <= A;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= acc_nx;
               q   <= {q[N-2:0], q_bit};
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  quot        <= {q[N-2:0], q_bit};
                  rem         <= acc_nx[N-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corners plus random pairs vs. an arithmetic model.
module tb_seq_divider;
   import rk_arith_pkg::*;

   localparam int N = RK_W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] A = '0;
   logic [N-1:0] B = '0;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] quot;
   logic [N-1:0] rem;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one operation from IDLE, wait for the result and check it against
   // plain integer division; hold_ready keeps out_ready high throughout.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic hold_ready);
      int           lat;
      logic [N-1:0] eq, er;
      if (b == '0) begin
         eq = '1;
         er = a;
      end else begin
         eq = a / b;
         er = a % b;
      end
      chk("in_ready_before_op", 32'(in_ready), 1);
      A = a; B = b; in_valid = 1'b1; out_ready = hold_ready;
      tick;
      in_valid = 1'b0;
      A = N'($urandom); B = N'($urandom);
      lat = 0;
      while (!out_valid && lat < 3*N) begin
         tick;
         lat++;
      end
      chk("latency_edges", 32'(lat), (b == '0) ? 32'd0 : 32'(N));
      chk("quot", 32'(quot), 32'(eq));
      chk("rem", 32'(rem), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), (b == '0) ? 32'd1 : 32'd0);
      if (b != '0) begin
         chk("identity_qb_plus_r", 32'(quot) * 32'(b) + 32'(rem), 32'(a));
         chk("rem_lt_b", 32'(rem < b), 1);
      end
      out_ready = 1'b1;
      tick;
      out_ready = hold_ready;
      chk("out_valid_after_take", 32'(out_valid), 0);
      chk("in_ready_after_take", 32'(in_ready), 1);
      chk("quot_held_idle", 32'(quot), 32'(eq));
   endtask

   initial begin
      int lat;

      // Reset state
      rst_n = 1'b0;
      tick; tick;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_quot", 32'(quot), 0);
      chk("rst_rem", 32'(rem), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      rst_n = 1'b1;
      tick;

      // Basic and extreme operands, divide by zero
      run_op(16'd100, 16'd7, 1'b0);
      run_op(16'hFFFF, 16'd1, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 1'b0);
      run_op(16'd5, 16'd9, 1'b0);
      run_op(16'd0, 16'd5, 1'b0);
      run_op(16'd1234, 16'd0, 1'b0);

      // Busy input ignored during CALC, then backpressure in DONE
      A = 16'd200; B = 16'd7; in_valid = 1'b1; out_ready = 1'b0;
      tick;
      in_valid = 1'b0;
      repeat (3) tick;
      A = 16'd9; B = 16'd3; in_valid = 1'b1;
      tick;
      chk("busy_in_ready_0", 32'(in_ready), 0);
      tick;
      chk("busy_in_ready_1", 32'(in_ready), 0);
      in_valid = 1'b0; A = '0; B = '0;
      lat = 0;
      while (!out_valid && lat < 3*N) begin
         tick;
         lat++;
      end
      chk("busy_out_valid", 32'(out_valid), 1);
      chk("busy_quot", 32'(quot), 28);
      chk("busy_rem", 32'(rem), 4);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_quot", 32'(quot), 28);
         chk("bp_rem", 32'(rem), 4);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("bp_released_in_ready", 32'(in_ready), 1);
      chk("bp_released_out_valid", 32'(out_valid), 0);

      // Reset in the middle of a computation
      A = 16'd1000; B = 16'd3; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (8) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_quot", 32'(quot), 0);
      chk("midrst_rem", 32'(rem), 0);
      run_op(16'd1000, 16'd3, 1'b0);

      // Back-to-back random pairs with out_ready held high
      for (int i = 0; i < 200; i++) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom);
         rb = (i % 4 == 0) ? N'($urandom_range(1, 15)) : N'($urandom_range(1, 65535));
         run_op(ra, rb, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
